// File: rtl/bus_wr_master_if.sv
// rtl/bus_wr_master_if.sv - command queue and bus-side signals of the write master
interface bus_wr_master_if #(
    parameter int DEPTH = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic [31:0]              req_addr;
    logic [31:0]              req_data;
    logic                     cs;
    logic                     wr;
    logic [31:0]              addr;
    logic [31:0]              data;
    logic                     wr_done;
    logic                     busy;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        input  req_valid, req_addr, req_data,
        output req_ready, cs, wr, addr, data, wr_done, busy, level
    );

    modport slave (
        output req_valid, req_addr, req_data,
        input  req_ready, cs, wr, addr, data, wr_done, busy, level
    );
endinterface

// File: rtl/bus_wr_master.sv
// rtl/bus_wr_master.sv - queued write master driving an active-low cs/wr strobe bus
module bus_wr_master #(
    parameter int DEPTH      = 4,
    parameter int STROBE_CYC = 3,
    parameter int GAP_CYC    = 1
) (
    input  logic            clk,
    input  logic            rst,
    bus_wr_master_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [31:0]   mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          cs_q;
    logic          wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
    logic          done_q;
    logic          push;
    logic          pop;

    // Ready depends only on the stored level, so a pop on the same edge never frees a slot early.
    assign bus.req_ready = (level_q != LW'(DEPTH));
    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = (state == IDLE) && (level_q != '0);

    assign bus.level   = level_q;
    assign bus.busy    = (state != IDLE) || (level_q != '0);
    assign bus.cs      = cs_q;
    assign bus.wr      = wr_q;
    assign bus.addr    = addr_q;
    assign bus.data    = data_q;
    assign bus.wr_done = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                mem_addr[wr_ptr] <= bus.req_addr;
                mem_data[wr_ptr] <= bus.req_data;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (!push && pop) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            cs_q   <= 1'b1;
            wr_q   <= 1'b1;
            addr_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        addr_q <= mem_addr[rd_ptr];
                        data_q <= mem_data[rd_ptr];
                        cs_q   <= 1'b0;
                        wr_q   <= 1'b0;
                        cnt    <= 4'(STROBE_CYC);
                        state  <= STROBE;
                    end
                end
                STROBE: begin
                    if (cnt == 4'd1) begin
                        cs_q   <= 1'b1;
                        wr_q   <= 1'b1;
                        addr_q <= '0;
                        data_q <= '0;
                        done_q <= 1'b1;
                        cnt    <= 4'(GAP_CYC);
                        state  <= GAP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                GAP: begin
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/bus_wr_master.md
BUS_WR_MASTER -- requirements
Module: bus_wr_master

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, command FIFO entries (power of 2, 2..16).
REQ-002 SHALL provide parameter STROBE_CYC, default 3, clocks cs/wr held low per write (1..15).
REQ-003 SHALL provide parameter GAP_CYC, default 1, minimum clocks cs/wr high between writes (1..15).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  write command offered.
REQ-007 req_ready  output  1  FIFO can accept a command.
REQ-008 req_addr  input  32  command address.
REQ-009 req_data  input  32  command write data.
REQ-010 cs  output  1  bus chip select, active-low.
REQ-011 wr  output  1  bus write strobe, active-low.
REQ-012 addr  output  32  bus address.
REQ-013 data  output  32  bus write data.
REQ-014 wr_done  output  1  one-clock pulse when a write completes.
REQ-015 busy  output  1  FIFO non-empty or write/gap in progress.
REQ-016 level  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 SHALL accept a command on any rising edge where req_valid=1 and req_ready=1; command written at FIFO tail.
REQ-018 SHALL drive req_ready = (level != DEPTH), from registered state only; no push when full, even if a pop occurs the same edge.
REQ-019 SHALL support a simultaneous push and pop when not full; level unchanged.
REQ-020 SHALL implement FSM states IDLE, STROBE, GAP.
REQ-021 IDLE: on an edge with level!=0, SHALL pop head, register addr/data, set cs=0, wr=0, enter STROBE; if level=0, remain IDLE.
REQ-022 STROBE: SHALL hold cs=0, wr=0, addr, data stable for exactly STROBE_CYC clocks, then set cs=1, wr=1, addr=0, data=0, pulse wr_done for one clock, enter GAP.
REQ-023 GAP: SHALL hold cs=1, wr=1 for exactly GAP_CYC clocks, then enter IDLE; IDLE may start the next write on the following edge, so back-to-back high time is GAP_CYC+1 clocks.
REQ-024 Latency: a command pushed at edge k into an empty FIFO with FSM in IDLE SHALL see cs=0 after edge k+1 and cs=1 after edge k+1+STROBE_CYC.
REQ-025 cs and wr SHALL always be equal and glitch-free (registered outputs).
REQ-026 addr/data SHALL be 0 whenever cs=1.
REQ-027 Commands SHALL issue on the bus in acceptance order; none dropped, none duplicated.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow.
REQ-029 busy = (state!=IDLE) or (level!=0).
REQ-030 Strobe/gap counters SHALL be 4 bits, counting down to 1; no other width dependency.

Reset
REQ-031 rst=1 at an edge SHALL set: state IDLE, cs=1, wr=1, addr=0, data=0, wr_done=0, level=0, req_ready=1 (after edge), busy=0, pointers 0.
REQ-032 rst during STROBE SHALL abort the write: cs/wr high after that edge, no wr_done pulse, FIFO contents discarded.
REQ-033 A req_valid presented on the same edge as rst=1 SHALL NOT be accepted.

Verification
REQ-034 Single write: push (32'h1100008a, 32'h11113000) at edge 2 after reset -> cs=wr=0 after edges 3..5 with addr=32'h1100008a, data=32'h11113000; cs=1 and wr_done=1 after edge 6.
REQ-035 Fill: push 5 commands back-to-back with DEPTH=4, FSM idle -> 5th held while req_ready=0; all 5 appear on the bus in order, each 3-clock strobe, 2-clock minimum high between strobes.
REQ-036 Simultaneous push/pop: level=2, push on the edge IDLE pops -> level stays 2, order preserved.
REQ-037 Reset mid-strobe: assert rst on 2nd strobe clock with 3 queued -> cs=1, level=0, no wr_done, busy=0; next push starts normally.
REQ-038 Wrap: push/issue 10 commands, data 1..10, DEPTH=4 -> bus data sequence 1..10 exactly, level returns to 0, busy=0.
REQ-039 Parameters: STROBE_CYC=1, GAP_CYC=1 -> one-clock strobes, 2-clock high between consecutive writes.
